// File: rtl/audio_codec_i2s.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | audio_codec_i2s : I2S master for a slave-mode stereo codec; mono DAC      |
// | playback of one 16-bit word per frame, left-channel ADC capture.          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module audio_codec_i2s #(
  parameter int BCLK_HALF = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] audio_output,
  output logic [15:0] audio_input,
  output logic        sample_end,
  output logic        sample_req,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_adclrck,
  output logic        aud_dacdat,
  input  logic        aud_adcdat
);

  localparam int              DIV_W    = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] divcnt_q, divcnt_d;
  logic             bclk_q, bclk_d;
  logic [5:0]       bitcnt_q, bitcnt_d;
  logic             lrck_q, lrck_d;
  logic             dacdat_q, dacdat_d;
  logic [15:0]      tx_word_q, tx_word_d;
  // Only 15 bits are kept: the 16th captured bit goes straight into audio_input.
  logic [14:0]      rx_q, rx_d;
  logic [15:0]      audio_input_q, audio_input_d;
  logic             sample_end_q, sample_end_d;
  logic             sample_req_q, sample_req_d;

  logic [5:0]       bit_next;
  logic [4:0]       slot_next;
  logic [3:0]       tx_idx;
  logic             tick;

  always_comb begin
    divcnt_d      = divcnt_q + 1'b1;
    bclk_d        = bclk_q;
    bitcnt_d      = bitcnt_q;
    lrck_d        = lrck_q;
    dacdat_d      = dacdat_q;
    tx_word_d     = tx_word_q;
    rx_d          = rx_q;
    audio_input_d = audio_input_q;
    sample_end_d  = 1'b0;
    sample_req_d  = 1'b0;
    tick          = (divcnt_q == DIV_LAST);
    bit_next      = bitcnt_q + 6'd1;
    slot_next     = bit_next[4:0];
    tx_idx        = 4'(5'd16 - slot_next);

    if (tick) begin
      divcnt_d = '0;
      bclk_d   = ~bclk_q;
      if (!bclk_q) begin
        // BCLK rising: capture left-slot data bits only
        if (bitcnt_q >= 6'd1 && bitcnt_q <= 6'd16) begin
          rx_d = {rx_q[13:0], aud_adcdat};
        end
        if (bitcnt_q == 6'd16) begin
          audio_input_d = {rx_q, aud_adcdat};
          sample_end_d  = 1'b1;
        end
      end else begin
        bitcnt_d = bit_next;
        lrck_d   = bit_next[5];
        dacdat_d = (slot_next >= 5'd1 && slot_next <= 5'd16) ? tx_word_q[tx_idx] : 1'b0;
        if (bit_next == 6'd0) begin
          tx_word_d = audio_output;
        end
        if (bit_next == 6'd63) begin
          sample_req_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divcnt_q      <= '0;
      bclk_q        <= 1'b0;
      bitcnt_q      <= 6'd0;
      lrck_q        <= 1'b0;
      dacdat_q      <= 1'b0;
      tx_word_q     <= 16'd0;
      rx_q          <= 15'd0;
      audio_input_q <= 16'd0;
      sample_end_q  <= 1'b0;
      sample_req_q  <= 1'b0;
    end else begin
      divcnt_q      <= divcnt_d;
      bclk_q        <= bclk_d;
      bitcnt_q      <= bitcnt_d;
      lrck_q        <= lrck_d;
      dacdat_q      <= dacdat_d;
      tx_word_q     <= tx_word_d;
      rx_q          <= rx_d;
      audio_input_q <= audio_input_d;
      sample_end_q  <= sample_end_d;
      sample_req_q  <= sample_req_d;
    end
  end

  assign audio_input = audio_input_q;
  assign sample_end  = sample_end_q;
  assign sample_req  = sample_req_q;
  assign aud_bclk    = bclk_q;
  assign aud_daclrck = lrck_q;
  assign aud_adclrck = lrck_q;
  assign aud_dacdat  = dacdat_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_codec_i2s.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_audio_codec_i2s : randomized bench with an edge-count reference model. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_audio_codec_i2s;

  localparam int BH        = 2;
  localparam int BIT_CLK   = 2 * BH;
  localparam int FRAME_CLK = 64 * BIT_CLK;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] audio_output;
  logic [15:0] audio_input;
  logic        sample_end, sample_req;
  logic        aud_bclk, aud_daclrck, aud_adclrck, aud_dacdat, aud_adcdat;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          e      = 0;
  int          phase  = 0;
  logic [15:0] m_tx = 16'd0, m_ain = 16'd0;
  logic [15:0] drv_out = 16'd0, pat = 16'd0, adc_pat = 16'd0;
  logic [15:0] cur_left = 16'd0, cur_right = 16'd0, want_left = 16'd0, want_right = 16'd0;
  logic        fb = 1'b0, adc_loop = 1'b0, rand_codec = 1'b1, codec_bit = 1'b0;

  always #5 clk = ~clk;

  assign audio_output = fb ? audio_input : drv_out;
  assign aud_adcdat   = adc_loop ? aud_dacdat : codec_bit;

  audio_codec_i2s #(.BCLK_HALF(BH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .audio_output(audio_output),
    .audio_input (audio_input),
    .sample_end  (sample_end),
    .sample_req  (sample_req),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .aud_adclrck (aud_adclrck),
    .aud_dacdat  (aud_dacdat),
    .aud_adcdat  (aud_adcdat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Bit position within the frame after ev clk edges since reset release.
  function automatic int bit_of(input int ev);
    return (ev / BIT_CLK) % 64;
  endfunction

  function automatic logic slot_bit(input int ev, input logic [15:0] w);
    int s;
    s = bit_of(ev) % 32;
    if (s >= 1 && s <= 16) return w[16 - s];
    return 1'b0;
  endfunction

  function automatic logic codec_f(input int ev, input logic [15:0] l, input logic [15:0] r);
    logic [15:0] w;
    w = (bit_of(ev) < 32) ? l : r;
    return slot_bit(ev, w);
  endfunction

  // Reference model: edges since release, per-frame DAC word, last captured left word.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e     <= 0;
      m_tx  <= 16'd0;
      m_ain <= 16'd0;
    end else begin
      e <= e + 1;
      if (((e + 1) % FRAME_CLK) == 0)
        m_tx <= fb ? m_ain : drv_out;
      if (((e + 1) % BIT_CLK) == BH && bit_of(e + 1) == 16)
        m_ain <= adc_loop ? m_tx : cur_left;
    end
  end

  always @(negedge clk) begin
    chk("bclk",        {31'd0, aud_bclk},    32'((e / BH) % 2));
    chk("daclrck",     {31'd0, aud_daclrck}, {31'd0, bit_of(e) >= 32});
    chk("adclrck",     {31'd0, aud_adclrck}, {31'd0, bit_of(e) >= 32});
    chk("dacdat",      {31'd0, aud_dacdat},  {31'd0, slot_bit(e, m_tx)});
    chk("sample_req",  {31'd0, sample_req},
        {31'd0, (e > 0) && (e % BIT_CLK == 0) && (bit_of(e) == 63)});
    chk("sample_end",  {31'd0, sample_end},
        {31'd0, (e % BIT_CLK == BH) && (bit_of(e) == 16)});
    chk("audio_input", {16'd0, audio_input}, {16'd0, m_ain});
    if (rst_n && e < FRAME_CLK)
      chk("frame0_zero", {31'd0, aud_dacdat}, 32'd0);
    if (phase != 0)
      chk("dac_pattern", {31'd0, aud_dacdat}, {31'd0, slot_bit(e, pat)});
    if ((phase == 1 || phase == 3) && sample_end)
      chk("adc_capture", {16'd0, audio_input}, {16'd0, adc_pat});
    if (e % FRAME_CLK == 1) begin
      cur_left  <= rand_codec ? 16'($urandom) : want_left;
      cur_right <= rand_codec ? 16'($urandom) : want_right;
    end
    codec_bit <= codec_f(e, cur_left, cur_right);
  end

  task automatic wait_bit(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && !hit; i++) begin
      @(posedge clk);
      #2;
      if (bit_of(e) == target) hit = 1'b1;
    end
    if (!hit) chk("wait_bitcnt", 32'(bit_of(e)), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got t=%0t expected end earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;

    // Random playback words at random times, random codec words per frame.
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(15) == 0) drv_out = 16'($urandom);
    end

    // Directed DAC pattern and ADC capture with distinct left/right words.
    rand_codec = 1'b0;
    want_left  = 16'h8001;
    want_right = 16'hFFFF;
    drv_out    = 16'hA5C3;
    pat        = 16'hA5C3;
    adc_pat    = 16'h8001;
    wait_bit(40);
    wait_bit(2);
    phase = 1;
    wait_bit(40);
    wait_bit(2);
    wait_bit(40);
    phase = 0;

    // Request timing: new word presented right after sample_req, late change ignored.
    drv_out = 16'h1234;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && !hit; i++) begin
      @(posedge clk);
      #2;
      if (sample_req) hit = 1'b1;
    end
    if (!hit) chk("sample_req_seen", {31'd0, sample_req}, 32'd1);
    @(posedge clk);
    #2 drv_out = 16'h7FFF;
    pat = 16'h7FFF;
    wait_bit(2);
    phase = 2;
    wait_bit(20);
    drv_out = 16'($urandom);
    wait_bit(62);
    phase = 0;

    // Asynchronous reset mid-frame.
    wait_bit(40);
    rst_n = 1'b0;
    #1;
    chk("rst_bclk",   {31'd0, aud_bclk},    32'd0);
    chk("rst_lrck",   {31'd0, aud_daclrck}, 32'd0);
    chk("rst_adclrck",{31'd0, aud_adclrck}, 32'd0);
    chk("rst_dacdat", {31'd0, aud_dacdat},  32'd0);
    chk("rst_req",    {31'd0, sample_req},  32'd0);
    chk("rst_end",    {31'd0, sample_end},  32'd0);
    chk("rst_ain",    {16'd0, audio_input}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_bit(40);

    // Loopback: DAC wired to ADC, then effects feedback recirculates the word.
    drv_out  = 16'h5A5A;
    pat      = 16'h5A5A;
    adc_pat  = 16'h5A5A;
    adc_loop = 1'b1;
    wait_bit(40);
    wait_bit(2);
    phase = 3;
    wait_bit(40);
    fb = 1'b1;
    drv_out = 16'($urandom);
    for (int f = 0; f < 10; f++) begin
      wait_bit(2);
      wait_bit(40);
    end
    phase = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
